// File: rtl/fetch_stage.sv
// Fetch stage: PC register plus a 2-entry {pc, instr} prefetch buffer; decode sees a fetch one cycle later.
// Backpressure: out_ready=0 holds the head entry stable, and the PC freezes once both buffer entries are occupied.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus8
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t        state;
  occ_t        state_nxt;
  logic [31:0] pc;
  logic [31:0] head_pc;
  logic [31:0] head_instr;
  logic [31:0] tail_pc;
  logic [31:0] tail_instr;
  logic        push;
  logic        pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    pop       = 1'b0;
    push      = 1'b0;
    state_nxt = state;
    pop  = (state != EMPTY) && out_ready;
    push = !redirect_valid && ((state != FULL) || pop);
    if (redirect_valid) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop) state_nxt = FULL;
          else if (pop && !push) state_nxt = EMPTY;
        end
        FULL:    if (pop && !push) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  // Dead slots are always zeroed so the outputs read 0 while empty without extra gating.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      head_pc    <= 32'h0;
      head_instr <= 32'h0;
      tail_pc    <= 32'h0;
      tail_instr <= 32'h0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head_pc    <= pc;
            head_instr <= imem_rd;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_pc    <= pc;
            head_instr <= imem_rd;
          end else if (push) begin
            tail_pc    <= pc;
            tail_instr <= imem_rd;
          end else if (pop) begin
            head_pc    <= 32'h0;
            head_instr <= 32'h0;
          end
        end
        FULL: begin
          if (pop) begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            if (push) begin
              tail_pc    <= pc;
              tail_instr <= imem_rd;
            end else begin
              tail_pc    <= 32'h0;
              tail_instr <= 32'h0;
            end
          end
        end
        default: begin
          head_pc    <= 32'h0;
          head_instr <= 32'h0;
          tail_pc    <= 32'h0;
          tail_instr <= 32'h0;
        end
      endcase
    end
  end

  assign imem_a       = pc;
  assign out_valid    = (state != EMPTY);
  assign out_pc       = head_pc;
  assign out_instr    = head_instr;
  assign out_pc_plus8 = head_pc + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, hand sequences for stall/redirect/wrap/reset, then random traffic vs a queue model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv;
  logic        rdy;
  logic [31:0] rpc;

  logic [31:0] imem_a, imem_rd, out_instr, out_pc, out_pc_plus8;
  logic        out_valid;
  logic [31:0] imem_a_w, imem_rd_w, out_instr_w, out_pc_w, out_pc_plus8_w;
  logic        out_valid_w;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'hE000_0000 + (a >> 2);
  endfunction

  assign imem_rd   = imem_word(imem_a);
  assign imem_rd_w = imem_word(imem_a_w);

  fetch_stage dut (
    .clk(clk), .reset(rst), .imem_a(imem_a), .imem_rd(imem_rd),
    .redirect_valid(rv), .redirect_pc(rpc), .out_valid(out_valid),
    .out_ready(rdy), .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus8(out_pc_plus8)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(rst), .imem_a(imem_a_w), .imem_rd(imem_rd_w),
    .redirect_valid(rv), .redirect_pc(rpc), .out_valid(out_valid_w),
    .out_ready(rdy), .out_instr(out_instr_w), .out_pc(out_pc_w), .out_pc_plus8(out_pc_plus8_w)
  );

  // Reference model for the default instance: fetch PC plus an ordered queue of up to two entries.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] pc_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      q.delete();
      pc_m = 32'h0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (rv) begin
        q.delete();
        pc_m = rpc & 32'hFFFF_FFFC;
      end else if (q.size() < 2) begin
        q.push_back('{pc: pc_m, instr: imem_word(pc_m)});
        pc_m = pc_m + 32'd4;
      end
    end
  endtask

  task automatic model_cmp();
    logic [31:0] epc, ein;
    epc = (q.size() > 0) ? q[0].pc : 32'h0;
    ein = (q.size() > 0) ? q[0].instr : 32'h0;
    chk("rnd_valid", {31'h0, out_valid}, {31'h0, q.size() > 0});
    chk("rnd_pc", out_pc, epc);
    chk("rnd_instr", out_instr, ein);
    chk("rnd_pc_plus8", out_pc_plus8, epc + 32'd8);
    chk("rnd_imem_a", imem_a, pc_m);
  endtask

  task automatic set_in(input logic r, input logic v, input logic [31:0] p, input logic y);
    rst = r;
    rv  = v;
    rpc = p;
    rdy = y;
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] ea;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] p, input logic y,
                              input logic c, input logic e, input logic [31:0] epc,
                              input logic [31:0] ein, input logic [31:0] ea);
    vec_t t;
    t.rst = r; t.rv = v; t.rpc = p; t.rdy = y; t.chk = c;
    t.ev = e; t.epc = epc; t.einstr = ein; t.ea = ea;
    return t;
  endfunction

  vec_t tbl[11];

  initial begin
    set_in(1'b1, 1'b0, 32'h0, 1'b0);

    tbl[0]  = mk(1, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,         32'h0);
    tbl[1]  = mk(0, 0, 32'h0,   1, 1, 0, 32'h0,  32'h0,         32'h0);
    tbl[2]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h0,  32'hE000_0000, 32'h4);
    tbl[3]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h4,  32'hE000_0001, 32'h8);
    tbl[4]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h4,  32'hE000_0001, 32'hC);
    tbl[5]  = mk(0, 1, 32'h43,  0, 1, 1, 32'h4,  32'hE000_0001, 32'hC);
    tbl[6]  = mk(0, 0, 32'h0,   1, 1, 0, 32'h0,  32'h0,         32'h40);
    tbl[7]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h40, 32'hE000_0010, 32'h44);
    tbl[8]  = mk(0, 1, 32'h100, 1, 1, 1, 32'h44, 32'hE000_0011, 32'h48);
    tbl[9]  = mk(1, 0, 32'h0,   0, 1, 0, 32'h0,  32'h0,         32'h100);
    tbl[10] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,  32'h0,         32'h0);

    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      @(negedge clk);
      if (tbl[i].chk) begin
        chk("tbl_valid", {31'h0, out_valid}, {31'h0, tbl[i].ev});
        chk("tbl_pc", out_pc, tbl[i].epc);
        chk("tbl_instr", out_instr, tbl[i].einstr);
        chk("tbl_pc_plus8", out_pc_plus8, tbl[i].epc + 32'd8);
        chk("tbl_imem_a", imem_a, tbl[i].ea);
      end
      adv();
    end

    // Stall: fill to FULL, hold out_ready low, then drain in order.
    set_in(1, 0, 32'h0, 0); @(negedge clk); adv();
    for (int i = 0; i < 7; i++) begin
      set_in(0, 0, 32'h0, 0);
      @(negedge clk);
      if (i >= 2) begin
        chk("stall_imem_a", imem_a, 32'h8);
        chk("stall_pc", out_pc, 32'h0);
        chk("stall_valid", {31'h0, out_valid}, 32'h1);
      end
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 32'h0, 1);
      @(negedge clk);
      chk("drain_pc", out_pc, 32'(i * 4));
      chk("drain_valid", {31'h0, out_valid}, 32'h1);
      adv();
    end

    // Redirect coinciding with a pop while FULL.
    set_in(1, 0, 32'h0, 0); @(negedge clk); adv();
    set_in(0, 0, 32'h0, 0); @(negedge clk); adv();
    set_in(0, 0, 32'h0, 0); @(negedge clk); adv();
    set_in(0, 1, 32'h303, 1); @(negedge clk);
    chk("rdpop_head_pc", out_pc, 32'h0);
    adv();
    set_in(0, 0, 32'h0, 1); @(negedge clk);
    chk("rdpop_flushed", {31'h0, out_valid}, 32'h0);
    chk("rdpop_imem_a", imem_a, 32'h300);
    adv();
    @(negedge clk);
    chk("rdpop_target", out_pc, 32'h300);
    chk("rdpop_target_p8", out_pc_plus8, 32'h308);
    adv();

    // Mid-run reset while FULL: no pre-reset entry from 0x200 may surface.
    set_in(0, 1, 32'h200, 0); @(negedge clk); adv();
    set_in(0, 0, 32'h0, 0); @(negedge clk); adv();
    @(negedge clk); adv();
    @(negedge clk);
    chk("pre_rst_pc", out_pc, 32'h200);
    adv();
    set_in(1, 0, 32'h0, 0); @(negedge clk); adv();
    set_in(0, 0, 32'h0, 1); @(negedge clk);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_imem_a", imem_a, 32'h0);
    chk("rst_pc_plus8", out_pc_plus8, 32'h8);
    adv();
    @(negedge clk);
    chk("rst_first_pc", out_pc, 32'h0);
    chk("rst_first_instr", out_instr, 32'hE000_0000);
    adv();

    // Wrap via the instance reset to 0xFFFF_FFF8.
    set_in(1, 0, 32'h0, 0); @(negedge clk); adv();
    set_in(0, 0, 32'h0, 1); @(negedge clk);
    chk("wrap_valid0", {31'h0, out_valid_w}, 32'h0);
    chk("wrap_imem_a0", imem_a_w, 32'hFFFF_FFF8);
    adv();
    @(negedge clk);
    chk("wrap_pc1", out_pc_w, 32'hFFFF_FFF8);
    adv();
    @(negedge clk);
    chk("wrap_pc2", out_pc_w, 32'hFFFF_FFFC);
    chk("wrap_p8_2", out_pc_plus8_w, 32'h0000_0004);
    chk("wrap_instr2", out_instr_w, 32'h1FFF_FFFF);
    adv();
    @(negedge clk);
    chk("wrap_pc3", out_pc_w, 32'h0000_0000);
    chk("wrap_valid3", {31'h0, out_valid_w}, 32'h1);
    adv();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(199) == 0, $urandom_range(99) < 8,
             ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(255)),
             $urandom_range(99) < 70);
      @(negedge clk);
      model_cmp();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 imem_a  output  32  word-aligned fetch address to instruction memory, with bits [1:0] always 0.
REQ-006 imem_rd  input  32  instruction word, combinationally valid for imem_a in the same cycle.
REQ-007 redirect_valid  input  1  branch/PC-write request, sampled at the clock edge.
REQ-008 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and forced to 0.
REQ-009 out_valid  output  1  head entry of the prefetch buffer is valid.
REQ-010 out_ready  input  1  downstream decode accepts the head entry this cycle.
REQ-011 out_instr  output  32  instruction word of the head entry.
REQ-012 out_pc  output  32  fetch address of the head entry.
REQ-013 out_pc_plus8  output  32  out_pc + 8, modulo 2^32, which is the architectural PC read value.

Function
REQ-014 The block SHALL hold a 32-bit fetch PC register and a 2-entry FIFO of {pc, instr} pairs.
REQ-015 The FIFO occupancy state machine SHALL have exactly three states: EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
REQ-016 imem_a SHALL equal the PC register at all times, including during stalls.
REQ-017 pop SHALL be asserted in a cycle exactly when out_valid=1 and out_ready=1.
REQ-018 push SHALL be asserted in a cycle exactly when redirect_valid=0 and (state != FULL, or pop=1).
- Consequence: a simultaneous push and pop is allowed in FULL.
REQ-019 On push, the pair {PC, imem_rd} SHALL be written at the FIFO tail, and PC SHALL advance to PC+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 When push=0 and redirect_valid=0, PC SHALL hold its value.
REQ-021 State transitions SHALL follow the push/pop pair:
- push only: EMPTY->ONE, ONE->FULL.
- pop only: FULL->ONE, ONE->EMPTY.
- push and pop together: the state is unchanged.
- neither: the state is unchanged.
REQ-022 The FIFO SHALL preserve ordering; the head entry is always the oldest unpopped entry.
REQ-023 out_valid SHALL be 1 exactly when state != EMPTY.
REQ-024 out_instr and out_pc SHALL be driven from the head entry registers.
- Latency: an instruction fetched in cycle N appears at the outputs in cycle N+1 at the earliest.
REQ-025 When out_valid=0, out_instr, out_pc and out_pc_plus8 SHALL be 32'h0, 32'h0 and 32'h8 respectively.
REQ-026 While out_valid=1 and out_ready=0, out_instr and out_pc SHALL stay stable until accepted.
REQ-027 On redirect_valid=1, the following SHALL happen at the next edge:
- PC loads {redirect_pc[31:2], 2'b00}.
- All FIFO entries are discarded and the state becomes EMPTY.
- No push occurs in that cycle.
REQ-028 If pop and redirect_valid coincide, the head transfer SHALL count as completed and the remaining entry SHALL be flushed.
REQ-029 A redirect while EMPTY SHALL only reload PC; fetching SHALL resume at the new PC in the following cycle.
REQ-030 Back-to-back redirects SHALL each take effect, and the last one SHALL determine PC.
REQ-031 With out_ready held at 1 and no redirect, the block SHALL sustain one instruction per cycle after the first fill cycle.

Reset
REQ-032 When reset=1 at a clock edge, the following SHALL take effect at that edge:
- PC is set to RESET_PC and the state to EMPTY.
- The FIFO entry registers are cleared to 0.
- Outputs are out_valid=0, out_instr=0, out_pc=0, out_pc_plus8=8, imem_a=RESET_PC.
REQ-033 Reset SHALL take priority over redirect_valid, push and pop.
- A reset asserted mid-stream discards all buffered entries.
REQ-034 Before the first reset edge, outputs are undefined; the bench SHALL apply reset for at least one cycle before checking any output.

Verification
REQ-035 Streaming: reset, imem model RAM[i]=32'hE000_0000+i, out_ready=1 -> starting the cycle after reset, out_instr/out_pc sequence is E000_0000/0, E000_0001/4, E000_0002/8, with out_valid=1 every cycle from the first valid output onward.
REQ-036 Stall: fill, then out_ready=0 for 5 cycles -> the state reaches FULL, PC freezes at 8, and imem_a=8 and out_pc=0 stay stable throughout.
REQ-036 (cont.) On release, out_pc follows 0, 4, 8 with no gap or duplicate.
REQ-037 Redirect: redirect_pc=32'h0000_0043 while FULL -> the next cycle has out_valid=0 and imem_a=32'h40, and the cycle after has out_pc=32'h40 and out_pc_plus8=32'h48.
REQ-038 Redirect with pop: out_ready=1 and redirect_valid=1 together while FULL -> the head is consumed once, the second entry never appears, and the next valid out_pc equals the redirect target.
REQ-039 Wrap: RESET_PC=32'hFFFF_FFF8 -> the out_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, and out_pc_plus8 for FFFF_FFFC is 0000_0004.
REQ-040 Mid-run reset: assert reset while FULL with out_ready=0 -> the next cycle has out_valid=0 and imem_a=RESET_PC, and no pre-reset entry ever reaches the output.
